// File: rtl/adder_stream_pkg.sv
// Shared types and defaults for the adder stream driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_stream_pkg;

  // Operand/result width of the registered adder this driver feeds.
  localparam int W_DEF = 8;

  // Clock edges from the issue edge to the result-capture cycle:
  // one for the adder's input register, one for its output register.
  localparam int LAT_DEF = 2;

  typedef logic [W_DEF-1:0] data_t;

  typedef struct packed {
    data_t a;
    data_t b;
  } pair_t;

endpackage

// File: rtl/adder_stream_driver_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and occupancy count.
// Latency: data pushed at edge N is visible at the head after edge N (no bypass).
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Equal pointers mean empty; same index with differing wrap bit means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; simultaneous push and pop both advance.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/adder_stream_driver.sv
// Streams operand pairs into an external registered adder and buffers its results.
// Latency: input handshake at edge E -> issue at E+1 -> result at out head after E+3 (LAT=2).
// Backpressure: issue only while output credits remain, so no result is ever dropped.
module adder_stream_driver
  import adder_stream_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int LAT       = LAT_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_a_i,
  input  logic [W-1:0]     in_b_i,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  input  logic [W-1:0]     res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_sum_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_pair_t;

  op_pair_t          in_push_dat;
  op_pair_t          in_head;
  logic              in_push;
  logic              in_full;
  logic              in_empty;
  logic [IN_CW-1:0]  in_count;

  logic              out_push;
  logic              out_pop;
  logic              out_full;
  logic              out_empty;
  logic [OUT_CW-1:0] out_count;

  logic              run_q;
  logic [LAT-1:0]    v_q;
  logic              issue;
  logic              capture;
  int                inflight;

  // ---------------------------------------------------------------------------
  // Input side: ready is held low until the first edge after reset release.
  // ---------------------------------------------------------------------------
  assign in_ready_o  = run_q && !in_full;
  assign in_push     = in_valid_i && in_ready_o;
  assign in_push_dat = '{a: in_a_i, b: in_b_i};

  sync_fifo #(
    .WIDTH (2*W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk_i    (clk_i),
    .rst_n    (reset_i),
    .push     (in_push),
    .push_dat (in_push_dat),
    .pop      (issue),
    .pop_dat  (in_head),
    .full     (in_full),
    .empty    (in_empty),
    .count    (in_count)
  );

  // Ready enable: released synchronously one edge after reset deasserts.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Credit check: registered output occupancy plus results still in the adder
  // must leave room for one more. A same-cycle output pop is not counted, so
  // credit returns one cycle late but can never overcommit.
  // ---------------------------------------------------------------------------
  // Count in-flight results and decide whether to issue this cycle.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT; i++) begin
      if (v_q[i]) inflight = inflight + 1;
    end
    issue = !in_empty && ((int'(out_count) + inflight) < OUT_DEPTH);
  end

  // Issue register: present the FIFO head to the adder; hold otherwise.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      a_o <= '0;
      b_o <= '0;
    end else if (issue) begin
      a_o <= in_head.a;
      b_o <= in_head.b;
    end
  end

  // In-flight valid pipe tracking each issued pair through the adder.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) v_q <= '0;
    else          v_q <= {v_q[LAT-2:0], issue};
  end

  // ---------------------------------------------------------------------------
  // Output side: the adder's result is valid while the last pipe stage is set.
  // ---------------------------------------------------------------------------
  assign capture     = v_q[LAT-1];
  assign out_push    = capture;
  assign out_valid_o = !out_empty;
  assign out_pop     = out_valid_o && out_ready_i;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i    (clk_i),
    .rst_n    (reset_i),
    .push     (out_push),
    .push_dat (res_i),
    .pop      (out_pop),
    .pop_dat  (out_sum_o),
    .full     (out_full),
    .empty    (out_empty),
    .count    (out_count)
  );

  // Completed-transaction counter, wraps naturally at all-ones.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)     done_cnt_o <= '0;
    else if (out_pop) done_cnt_o <= done_cnt_o + 1'b1;
  end

  // A capture into a full output buffer would silently drop a result.
  a_no_capture_when_full : assert property (
    @(posedge clk_i) disable iff (!reset_i) !(capture && out_full)
  );

  // Input occupancy can never exceed the buffer size.
  a_in_count_bound : assert property (
    @(posedge clk_i) disable iff (!reset_i) int'(in_count) <= IN_DEPTH
  );

endmodule

// File: tb/tb_adder_stream_driver.sv
// Directed bench with a scoreboard for adder_stream_driver plus a registered adder model.
// A second instance with a 4-bit counter shares all stimulus to exercise counter wrap.
// Expected sums are queued on each accepted input and compared as the DUT pops them.
module tb_adder_stream_driver;

  logic       clk;
  logic       reset_i;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] a_o;
  logic [7:0] b_o;
  logic [7:0] res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [15:0] done_cnt;

  logic       in_ready4;
  logic [7:0] a4;
  logic [7:0] b4;
  logic [7:0] res4;
  logic       out_valid4;
  logic [7:0] out_sum4;
  logic [3:0] done_cnt4;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [7:0] exp_q[$];

  adder_stream_driver dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .a_o         (a_o),
    .b_o         (b_o),
    .res_i       (res),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .done_cnt_o  (done_cnt)
  );

  adder_stream_driver #(.CNT_W(4)) dut4 (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready4),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .a_o         (a4),
    .b_o         (b4),
    .res_i       (res4),
    .out_valid_o (out_valid4),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum4),
    .done_cnt_o  (done_cnt4)
  );

  // Registered 8-bit adders with synchronous reset, one per instance.
  always @(posedge clk) begin
    if (!reset_i) begin
      res  <= '0;
      res4 <= '0;
    end else begin
      res  <= a_o + b_o;
      res4 <= a4 + b4;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expected sum.
  always @(negedge clk) begin
    if (reset_i === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out: got %0d expected none", out_sum);
      end else begin
        chk("out_sum", {24'd0, out_sum}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair and hold it until accepted (bounded); returns the stall count.
  task automatic send(input logic [7:0] a, input logic [7:0] b, output int stalls);
    logic acc;
    logic [7:0] s;
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    stalls = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc) stalls++;
    end
    in_valid = 1'b0;
    if (acc) begin
      s = a + b;
      exp_q.push_back(s);
    end else begin
      chk("send_timeout", 32'd0, 32'd1);
    end
  endtask

  // Wait until every expected result has been delivered; returns cycles waited.
  task automatic drain(output int n);
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  initial begin
    int st;
    int total_st;
    int n;
    int p0;
    int acc_n;
    logic ok;
    adder_stream_pkg::pair_t bp_pair;

    reset_i   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_a_o", a_o, 0);
    chk("rst_b_o", b_o, 0);
    @(negedge clk);
    reset_i = 1'b1;

    // Single transaction: out_valid rises exactly 3 edges after the handshake edge.
    send(8'd3, 8'd4, st);
    @(negedge clk); chk("lat_e1_valid", out_valid, 0);
    @(negedge clk); chk("lat_e2_valid", out_valid, 0);
    @(negedge clk); chk("lat_e3_valid", out_valid, 0);
    @(negedge clk); chk("lat_e4_valid", out_valid, 1);
    chk("lat_sum", out_sum, 7);
    @(negedge clk); chk("single_done_cnt", done_cnt, 1);
    step();

    // Carry dropped on overflow, results kept in order.
    send(8'd200, 8'd100, st);
    send(8'd255, 8'd1, st);
    drain(n);
    chk("wrap_done_cnt", done_cnt, 3);

    // Back-to-back streaming: no input stall, one result per cycle.
    p0 = pops;
    total_st = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 8'(2 * i), st);
      total_st += st;
    end
    chk("stream_in_stalls", total_st, 0);
    drain(n);
    chk("stream_tail_cycles", n, 4);
    chk("stream_pops", pops - p0, 16);
    chk("stream_done_cnt", done_cnt, 19);

    // Backpressure: consumer stalled, offer 10 pairs for 20 cycles.
    out_ready = 1'b0;
    p0 = pops;
    acc_n = 0;
    for (int c = 0; c < 20; c++) begin
      bp_pair.a = 8'(acc_n * 7 + 50);
      bp_pair.b = 8'(acc_n * 13 + 100);
      in_valid = (acc_n < 10);
      in_a = bp_pair.a;
      in_b = bp_pair.b;
      @(negedge clk);
      ok = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        exp_q.push_back(8'(bp_pair.a + bp_pair.b));
        acc_n++;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc_n, 8);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_no_pops", pops - p0, 0);
    out_ready = 1'b1;
    for (int j = 8; j < 10; j++) begin
      send(8'(j * 7 + 50), 8'(j * 13 + 100), st);
    end
    drain(n);
    chk("bp_pops", pops - p0, 10);
    chk("bp_done_cnt", done_cnt, 29);

    // Reset mid-flight: three pairs buffered/in flight, consumer stalled.
    out_ready = 1'b0;
    send(8'd10, 8'd20, st);
    send(8'd30, 8'd40, st);
    send(8'd50, 8'd60, st);
    step();
    chk("mid_pre_valid", out_valid, 1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done_cnt", done_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    out_ready = 1'b1;
    p0 = pops;
    send(8'd1, 8'd1, st);
    drain(n);
    repeat (10) step();
    chk("mid_post_pops", pops - p0, 1);
    chk("mid_post_done_cnt", done_cnt, 1);

    // Counter wrap on the 4-bit instance: 17 completions leave it at 1.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      send(8'(k + 3), 8'(k * 5), st);
    end
    drain(n);
    chk("wrap4_done_cnt", done_cnt4, 1);
    chk("wrap16_done_cnt", done_cnt, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
